// File: rtl/reg_file_param.sv
// reg_file_param: scoreboarded register file with one partial-word write
// port, three registered read operands with opcode-class routing,
// same-cycle write-to-read bypass and per-register busy bits that stall
// operand reads until the pending writer retires.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int REG_CNT  = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reg_reset_n,
    // operand read / decode side
    input  logic              rd_req,
    input  logic [1:0]        rd_mode,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] operand0,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic              rd_valid,
    output logic              rd_stall,
    // writeback side
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_mode,
    // scoreboard reservation from decode
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr
);

    localparam int HALF_W = DATA_W / 2;
    // REG_CNT widened to the address width plus one so that the range check
    // also works when REG_CNT equals 2^ADDR_W.
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(REG_CNT);

    typedef enum logic [1:0] {
        WR_FULL      = 2'd0,
        WR_LOW_HALF  = 2'd1,
        WR_HIGH_HALF = 2'd2,
        WR_LOW_BYTE  = 2'd3
    } wr_mode_e;

    typedef enum logic [1:0] {
        RD_R_TYPE   = 2'd0,
        RD_I_TYPE   = 2'd1,
        RD_BRANCH   = 2'd2,
        RD_RESERVED = 2'd3
    } rd_mode_e;

    logic [DATA_W-1:0]  regs [REG_CNT];
    logic [REG_CNT-1:0] busy;

    logic              wr_hit;
    logic              rsv_hit;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;

    logic [ADDR_W-1:0] src_addr    [3];
    logic [DATA_W-1:0] src_val     [3];
    logic [2:0]        src_blocked;
    logic [2:0]        src_used;

    logic [DATA_W-1:0] nxt_op0;
    logic [DATA_W-1:0] nxt_op1;
    logic [DATA_W-1:0] nxt_op2;
    logic              stall_now;
    logic              accept;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Merge write data into the old register value; unwritten bits keep
    // their previous contents.
    function automatic logic [DATA_W-1:0] merge_write(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] data,
        input wr_mode_e          mode
    );
        logic [DATA_W-1:0] res;
        res = old;
        case (mode)
            WR_FULL:      res = data;
            WR_LOW_HALF:  res[HALF_W-1:0] = data[HALF_W-1:0];
            WR_HIGH_HALF: res[DATA_W-1:HALF_W] = data[HALF_W-1:0];
            WR_LOW_BYTE:  res[7:0] = data[7:0];
            default:      res = old;
        endcase
        return res;
    endfunction

    // Write-port qualification and the post-merge value used by both the
    // storage update and the bypass path.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_hit    = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
        rsv_hit   = rsv_en && in_range(rsv_addr) && !is_zero_reg(rsv_addr);
        wr_old    = in_range(wr_addr) ? regs[wr_addr] : '0;
        wr_merged = merge_write(wr_old, wr_data, wr_mode_e'(wr_mode));
    end

    // Effective value and blocked status of each source address.
    always_comb begin
        src_addr[0] = rd_addr0;
        src_addr[1] = rd_addr1;
        src_addr[2] = rd_addr2;
        for (int i = 0; i < 3; i++) begin
            src_val[i]     = '0;
            src_blocked[i] = 1'b0;
            if (in_range(src_addr[i]) && !is_zero_reg(src_addr[i])) begin
                if (wr_hit && (wr_addr == src_addr[i])) begin
                    src_val[i] = wr_merged;
                end else begin
                    src_val[i] = regs[src_addr[i]];
                end
                // A same-cycle write retires the pending writer, so it unblocks.
                src_blocked[i] = busy[src_addr[i]] &&
                                 !(wr_hit && (wr_addr == src_addr[i]));
            end
        end
    end

    // Operand routing by opcode class and the accept / stall decision.
    always_comb begin
        src_used = 3'b111;
        nxt_op0  = src_val[0];
        nxt_op1  = src_val[1];
        nxt_op2  = src_val[2];
        case (rd_mode_e'(rd_mode))
            RD_I_TYPE: begin
                src_used = 3'b011;
                nxt_op2  = imm;
            end
            RD_BRANCH: begin
                src_used = 3'b011;
                nxt_op1  = src_val[0];
                nxt_op2  = src_val[1];
            end
            default: begin
                src_used = 3'b111;
            end
        endcase
        stall_now = rd_req && |(src_used & src_blocked);
        accept    = rd_req && !stall_now;
    end

    // Register storage: merged write into the addressed entry.
    always_ff @(posedge clk or negedge reg_reset_n) begin
        if (!reg_reset_n) begin
            // NOTE: the whole array is cleared on reset because reads after
            // reset must return 0; this keeps it in flops rather than RAM.
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            // NOTE: state is updated with non-blocking assignments so every
            // reader in this edge sees the pre-edge value.
            regs[wr_addr] <= wr_merged;
        end
    end

    // Scoreboard: a write retires the pending writer, a reserve marks a new
    // one; the reserve is applied last so the new writer wins a collision.
    always_ff @(posedge clk or negedge reg_reset_n) begin
        if (!reg_reset_n) begin
            busy <= '0;
        end else begin
            if (wr_hit) begin
                busy[wr_addr] <= 1'b0;
            end
            if (rsv_hit) begin
                busy[rsv_addr] <= 1'b1;
            end
        end
    end

    // Registered operands, one-cycle valid pulse and stall flag.
    always_ff @(posedge clk or negedge reg_reset_n) begin
        if (!reg_reset_n) begin
            operand0 <= '0;
            operand1 <= '0;
            operand2 <= '0;
            rd_valid <= 1'b0;
            rd_stall <= 1'b0;
        end else begin
            rd_valid <= accept;
            rd_stall <= stall_now;
            if (accept) begin
                operand0 <= nxt_op0;
                operand1 <= nxt_op1;
                operand2 <= nxt_op2;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param: directed steps from the test plan followed
// by a randomized phase, all compared against a behavioural model.
module tb_reg_file_param;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          reg_reset_n;
    logic          rd_req;
    logic [1:0]    rd_mode;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] imm;
    logic [DW-1:0] operand0;
    logic [DW-1:0] operand1;
    logic [DW-1:0] operand2;
    logic          rd_valid;
    logic          rd_stall;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_mode;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;

    int vectors;
    int miscompares;

    // Behavioural model state
    logic [DW-1:0] m_reg  [NR];
    bit            m_busy [NR];
    logic [DW-1:0] e_op   [3];
    bit            e_valid;
    bit            e_stall;

    reg_file_param #(
        .DATA_W  (DW),
        .REG_CNT (NR),
        .ADDR_W  (AW),
        .ZERO_REG(1'b1)
    ) dut (
        .clk        (clk),
        .reg_reset_n(reg_reset_n),
        .rd_req     (rd_req),
        .rd_mode    (rd_mode),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .imm        (imm),
        .operand0   (operand0),
        .operand1   (operand1),
        .operand2   (operand2),
        .rd_valid   (rd_valid),
        .rd_stall   (rd_stall),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mode    (wr_mode),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expd);
        vectors++;
        assert (obs === expd) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    // Partial-word write expressed with masks.
    function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] old,
                                                  input logic [DW-1:0] d,
                                                  input logic [1:0] mode);
        case (mode)
            2'd1:    return (old & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
            2'd2:    return (old & 32'h0000_FFFF) | ((d & 32'h0000_FFFF) << 16);
            2'd3:    return (old & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
            default: return d;
        endcase
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic [DW-1:0] nv);
        if (a == 5'd0) return '0;
        if (wr_en && wr_addr == a) return nv;
        return m_reg[a];
    endfunction

    function automatic bit model_blocked(input logic [AW-1:0] a);
        return (a != 5'd0) && m_busy[a] && !(wr_en && wr_addr == a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) e_op[i] = '0;
        e_valid = 1'b0;
        e_stall = 1'b0;
    endtask

    task automatic idle();
        rd_req = 1'b0; rd_mode = 2'd0; rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0; imm = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 2'd0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic set_rd(input logic [1:0] m, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [DW-1:0] iv);
        rd_req = 1'b1; rd_mode = m; rd_addr0 = a0; rd_addr1 = a1; rd_addr2 = a2; imm = iv;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mode = m;
    endtask

    task automatic set_rsv(input logic [AW-1:0] a);
        rsv_en = 1'b1; rsv_addr = a;
    endtask

    // One clock: predict from the model, clock the DUT, compare, update.
    task automatic step(input string tag);
        logic [DW-1:0] nv;
        logic [1:0]    m;
        bit            blocked;
        nv = model_merge(m_reg[wr_addr], wr_data, wr_mode);
        m  = (rd_mode == 2'd3) ? 2'd0 : rd_mode;
        blocked = model_blocked(rd_addr0) || model_blocked(rd_addr1) ||
                  ((m == 2'd0) && model_blocked(rd_addr2));
        if (rd_req && !blocked) begin
            e_valid = 1'b1;
            e_stall = 1'b0;
            e_op[0] = model_read(rd_addr0, nv);
            if (m == 2'd2) begin
                e_op[1] = model_read(rd_addr0, nv);
                e_op[2] = model_read(rd_addr1, nv);
            end else begin
                e_op[1] = model_read(rd_addr1, nv);
                e_op[2] = (m == 2'd1) ? imm : model_read(rd_addr2, nv);
            end
        end else begin
            e_valid = 1'b0;
            e_stall = rd_req;
        end
        @(posedge clk);
        #1;
        if (wr_en && wr_addr != 5'd0) m_reg[wr_addr] = nv;
        if (wr_en) m_busy[wr_addr] = 1'b0;
        if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        check({tag, ".op0"}, operand0, e_op[0]);
        check({tag, ".op1"}, operand1, e_op[1]);
        check({tag, ".op2"}, operand2, e_op[2]);
        check({tag, ".valid"}, {31'd0, rd_valid}, {31'd0, e_valid});
        check({tag, ".stall"}, {31'd0, rd_stall}, {31'd0, e_stall});
        @(negedge clk);
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        model_clear();
        reg_reset_n = 1'b1;
        #3 reg_reset_n = 1'b0;
        #1;
        check("reset.op0", operand0, '0);
        check("reset.op1", operand1, '0);
        check("reset.op2", operand2, '0);
        check("reset.valid", {31'd0, rd_valid}, '0);
        check("reset.stall", {31'd0, rd_stall}, '0);
        @(negedge clk);
        @(negedge clk);
        reg_reset_n = 1'b1;

        // Partial writes on R5
        set_wr(5'd5, 32'hAAAA_5555, 2'd0); step("pw.full");
        set_wr(5'd5, 32'h0000_1234, 2'd1); step("pw.low_half");
        set_wr(5'd5, 32'h0000_BEEF, 2'd2); step("pw.high_half");
        set_wr(5'd5, 32'h0000_0077, 2'd3); step("pw.low_byte");
        set_rd(2'd0, 5'd5, 5'd0, 5'd0, '0); step("pw.read");
        check("pw.r5", operand0, 32'hBEEF_1277);
        // Partial write bypassed into a same-cycle read
        set_wr(5'd5, 32'h0000_0012, 2'd3); set_rd(2'd0, 5'd5, 5'd5, 5'd5, '0); step("pw.bypass");

        // Operand routing
        set_wr(5'd1, 32'd10, 2'd0); step("rt.w1");
        set_wr(5'd2, 32'd20, 2'd0); step("rt.w2");
        set_wr(5'd3, 32'd30, 2'd0); step("rt.w3");
        set_rd(2'd0, 5'd1, 5'd2, 5'd3, 32'd99); step("rt.rtype");
        check("rt.rtype.op2", operand2, 32'd30);
        set_rd(2'd1, 5'd1, 5'd2, 5'd3, 32'd99); step("rt.itype");
        check("rt.itype.op2", operand2, 32'd99);
        set_rd(2'd2, 5'd1, 5'd2, 5'd3, 32'd99); step("rt.branch");
        check("rt.branch.op1", operand1, 32'd10);
        set_rd(2'd3, 5'd1, 5'd2, 5'd3, 32'd99); step("rt.reserved");
        step("rt.idle");

        // Scoreboard stall on R4, released by a bypassed write
        set_rsv(5'd4); step("sb.reserve");
        set_rd(2'd0, 5'd1, 5'd4, 5'd3, '0); step("sb.stall1");
        check("sb.stall1.flag", {31'd0, rd_stall}, 32'd1);
        set_rd(2'd0, 5'd1, 5'd4, 5'd3, '0); step("sb.stall2");
        set_rd(2'd0, 5'd1, 5'd4, 5'd3, '0); set_wr(5'd4, 32'h55, 2'd0); step("sb.release");
        check("sb.release.op1", operand1, 32'h55);
        set_rd(2'd0, 5'd1, 5'd4, 5'd3, '0); step("sb.cleared");
        // Unused source in I-type does not stall
        set_rsv(5'd8); step("sb.rsv8");
        set_rd(2'd1, 5'd1, 5'd2, 5'd8, 32'h1); step("sb.unused_src");
        set_rd(2'd0, 5'd1, 5'd2, 5'd8, 32'h1); step("sb.used_src");
        set_wr(5'd8, 32'h88, 2'd0); step("sb.clear8");

        // Reserve and write on R6 together: written and left busy
        set_rsv(5'd6); set_wr(5'd6, 32'h66, 2'd0); step("sim.rsv_wr");
        set_rd(2'd0, 5'd6, 5'd1, 5'd2, '0); step("sim.stall");
        set_rd(2'd0, 5'd6, 5'd1, 5'd2, '0); set_wr(5'd6, 32'h67, 2'd1); step("sim.release");
        // Reserve concurrent with a read of the same register
        set_rsv(5'd7); set_rd(2'd0, 5'd7, 5'd1, 5'd2, '0); step("sim.rsv_read");
        set_rd(2'd0, 5'd7, 5'd1, 5'd2, '0); step("sim.rsv_after");
        set_wr(5'd7, 32'h77, 2'd0); step("sim.clear7");

        // Zero register ignores writes and reserves
        set_wr(5'd0, 32'hFFFF_FFFF, 2'd0); set_rsv(5'd0); set_rd(2'd0, 5'd0, 5'd0, 5'd0, '0); step("zr.bypass");
        set_rd(2'd0, 5'd0, 5'd0, 5'd0, '0); step("zr.read");
        check("zr.read.op0", operand0, 32'd0);

        // Randomized phase on a small address window for frequent collisions
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                set_rd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), $urandom);
            end
            if ($urandom_range(0, 1) != 0) begin
                set_wr(5'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 3) == 0) begin
                set_rsv(5'($urandom_range(0, 7)));
            end
            step("rnd");
        end

        // Asynchronous reset between edges with live state
        set_wr(5'd9, 32'h1234_5678, 2'd0); step("ar.load");
        set_rd(2'd0, 5'd9, 5'd9, 5'd9, '0); step("ar.read");
        #2 reg_reset_n = 1'b0;
        #1;
        check("ar.op0", operand0, '0);
        check("ar.op1", operand1, '0);
        check("ar.op2", operand2, '0);
        check("ar.valid", {31'd0, rd_valid}, '0);
        check("ar.stall", {31'd0, rd_stall}, '0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reg_reset_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            set_rd(2'd0, 5'(i), 5'(i), 5'(i), '0);
            step("ar.regs");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
